// File: rtl/fifo_burst_ctrl.sv
// FIFO sequencer: non-stalling write path with overflow counting,
// burst read path with timeout-driven partial flush.
module fifo_burst_ctrl #(
   parameter int DW        = 8,
   parameter int AW        = 8,
   parameter int BURST_LEN = 16,
   parameter int TIMEOUT   = 64
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   input  logic          sink_ready,
   input  logic          fifo_full,
   input  logic          fifo_empty,
   input  logic [AW-1:0] fifo_usedw,
   input  logic [DW-1:0] fifo_po_data,
   output logic          fifo_wr_reg,
   output logic [DW-1:0] fifo_pi_data,
   output logic          fifo_rd_reg,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          busy,
   output logic [15:0]   drop_cnt
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [AW:0]   FULL_OCC = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0]   BLEN     = (AW+1)'(BURST_LEN);
   localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      TAIL
   } state_t;

   state_t        state;
   logic [AW:0]   occ;
   logic [AW:0]   len;
   logic [AW:0]   rd_cnt;
   logic [TW-1:0] tmo_cnt;
   logic          rd_last;

   // usedw wraps to 0 when full, so full alone stands for 2**AW
   assign occ = fifo_full ? FULL_OCC : {1'b0, fifo_usedw};

   assign fifo_wr_reg  = in_valid & ~fifo_full & sys_rst_n;
   assign fifo_pi_data = in_data;
   assign out_data     = fifo_po_data;

   assign rd_last = (state == READ) && (rd_cnt == len - (AW+1)'(1));

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state       <= IDLE;
         fifo_rd_reg <= 1'b0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         busy        <= 1'b0;
         tmo_cnt     <= '0;
         rd_cnt      <= '0;
         len         <= '0;
      end else begin
         out_valid <= fifo_rd_reg;
         out_last  <= rd_last;
         unique case (state)
            IDLE: begin
               if (fifo_empty || fifo_wr_reg)
                  tmo_cnt <= '0;
               else if (tmo_cnt != TMAX)
                  tmo_cnt <= tmo_cnt + TW'(1);
               if (sink_ready && occ >= BLEN) begin
                  state       <= READ;
                  len         <= BLEN;
                  rd_cnt      <= '0;
                  fifo_rd_reg <= 1'b1;
                  busy        <= 1'b1;
               end else if (sink_ready && tmo_cnt == TMAX
                            && !fifo_empty) begin
                  state       <= READ;
                  len         <= occ;
                  rd_cnt      <= '0;
                  fifo_rd_reg <= 1'b1;
                  busy        <= 1'b1;
               end
            end
            READ: begin
               tmo_cnt <= '0;
               if (rd_last) begin
                  state       <= TAIL;
                  fifo_rd_reg <= 1'b0;
               end else begin
                  rd_cnt <= rd_cnt + (AW+1)'(1);
               end
            end
            TAIL: begin
               state   <= IDLE;
               busy    <= 1'b0;
               tmo_cnt <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n)
         drop_cnt <= '0;
      else if (in_valid && fifo_full && drop_cnt != 16'hFFFF)
         drop_cnt <= drop_cnt + 16'd1;
   end

endmodule
